// File: rtl/mips_debug.sv
// mips_debug
//   Debug controller sitting between the UART and the MIPS pipeline. A step
//   command byte ('s') from the UART produces a one-cycle step pulse to the
//   pipeline, after which a snapshot frame is streamed out through the UART
//   transmitter: the PC, every register-file entry, then the ALU result.
//   Each word goes out MSB byte first with a ready/done handshake.
//
// Ports
//   i_clk                  : clock, rising edge
//   i_reset                : synchronous active-high reset
//   i_uart_rx_ready        : i_uart_rx_data valid this cycle
//   i_uart_rx_data         : received byte
//   i_uart_tx_done         : transmitter consumed the presented byte (level)
//   i_mips_pc              : pipeline program counter
//   i_mips_register        : register-file read data for o_mips_register_number
//   i_mips_alu_result      : ALU result
//   o_mips_register_number : register-file read address
//   o_uart_tx_data         : byte to transmit
//   o_uart_tx_ready        : request to transmit o_uart_tx_data
//   o_step                 : one-cycle pipeline step pulse
module mips_debug #(
    parameter int NB               = 32,
    parameter int DATA_BITS        = 8,
    parameter int NUMBER_REGISTERS = 32
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_uart_rx_ready,
    input  logic [DATA_BITS-1:0]                      i_uart_rx_data,
    input  logic                                      i_uart_tx_done,
    input  logic [NB-1:0]                             i_mips_pc,
    input  logic [NB-1:0]                             i_mips_register,
    input  logic [NB-1:0]                             i_mips_alu_result,
    output logic [$clog2(NUMBER_REGISTERS+1)-1:0]     o_mips_register_number,
    output logic [DATA_BITS-1:0]                      o_uart_tx_data,
    output logic                                      o_uart_tx_ready,
    output logic                                      o_step
);

    localparam int RN_W  = $clog2(NUMBER_REGISTERS + 1);
    localparam int BYTES = NB / DATA_BITS;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WW    = $clog2(NUMBER_REGISTERS + 3);

    localparam logic [WW-1:0]        LAST_WORD = WW'(NUMBER_REGISTERS + 1);
    localparam logic [WW-1:0]        NUM_WORDS = WW'(NUMBER_REGISTERS + 2);
    localparam logic [BC_W-1:0]      LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [DATA_BITS-1:0] CMD_STEP  = DATA_BITS'(8'h73);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STEP = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_SEND = 3'd4,
        S_NEXT = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [NB-1:0]          buf_q, buf_d;
    logic [BC_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [WW-1:0]          word_idx_q, word_idx_d;
    logic [RN_W-1:0]        reg_num_q, reg_num_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   step_q, step_d;

    logic                   last_byte;
    logic                   words_remain;
    logic                   is_reg_word;
    logic [NB-1:0]          sel_word;

    // word_idx_q counts words already latched, so it also selects the next one.
    assign last_byte    = (byte_cnt_q == LAST_BYTE);
    assign words_remain = (word_idx_q != NUM_WORDS);
    assign is_reg_word  = (word_idx_q != '0) && (word_idx_q != LAST_WORD);

    always_comb begin
        if (word_idx_q == '0) begin
            sel_word = i_mips_pc;
        end else if (word_idx_q == LAST_WORD) begin
            sel_word = i_mips_alu_result;
        end else begin
            sel_word = i_mips_register;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            reg_num_q  <= '0;
            tx_data_q  <= '0;
            tx_ready_q <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            reg_num_q  <= reg_num_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
            step_q     <= step_d;
        end
    end

    // The shift buffer is pure data and is always loaded before it is read.
    always_ff @(posedge i_clk) begin
        buf_q <= buf_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_uart_rx_ready && (i_uart_rx_data == CMD_STEP)) state_d = S_STEP;
            S_STEP: state_d = S_WAIT;
            S_WAIT: state_d = S_LOAD;
            S_LOAD: state_d = S_SEND;
            S_SEND: if (i_uart_tx_done) state_d = S_NEXT;
            S_NEXT: begin
                if (!last_byte) begin
                    state_d = S_SEND;
                end else if (words_remain) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic. Outputs are registered, so each value is
    // computed on the transition into the state that presents it. The word is
    // captured on entry to LOAD (the WAIT->LOAD and NEXT->LOAD edges).
    always_comb begin
        buf_d      = buf_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        reg_num_d  = reg_num_q;
        tx_data_d  = tx_data_q;
        tx_ready_d = 1'b0;
        step_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_data_d  = '0;
                reg_num_d  = '0;
                word_idx_d = '0;
                byte_cnt_d = '0;
                step_d     = (state_d == S_STEP);
            end
            S_STEP: ;
            S_WAIT: begin
                buf_d      = sel_word;
                word_idx_d = word_idx_q + 1'b1;
            end
            S_LOAD: begin
                byte_cnt_d = '0;
                tx_data_d  = buf_q[NB-1 -: DATA_BITS];
                tx_ready_d = 1'b1;
            end
            S_SEND: begin
                tx_ready_d = !i_uart_tx_done;
            end
            S_NEXT: begin
                if (!last_byte) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    buf_d      = buf_q << DATA_BITS;
                    tx_data_d  = buf_q[NB-DATA_BITS-1 -: DATA_BITS];
                    tx_ready_d = 1'b1;
                end else if (words_remain) begin
                    buf_d      = sel_word;
                    word_idx_d = word_idx_q + 1'b1;
                    // Advance the read address right after its data is taken,
                    // giving the register file a whole word of settle time.
                    if (is_reg_word) reg_num_d = reg_num_q + 1'b1;
                end else begin
                    tx_data_d = '0;
                    reg_num_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign o_mips_register_number = reg_num_q;
    assign o_uart_tx_data         = tx_data_q;
    assign o_uart_tx_ready        = tx_ready_q;
    assign o_step                 = step_q;

endmodule

// File: tb/tb_mips_debug.sv
// tb_mips_debug
//   Directed bench for mips_debug with a 5-entry register file. Drives a step
//   command, collects the streamed frame byte by byte and compares it with
//   hand-chosen PC, register and ALU words.
module tb_mips_debug;

    localparam int NR = 5;

    logic        clk;
    logic        rst;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_done;
    logic [31:0] pc;
    logic [31:0] reg_rd;
    logic [31:0] alu;
    logic [2:0]  reg_num;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        step;

    logic [31:0] regs [0:NR];
    int          checks;
    int          errors;
    logic        step_seen;

    mips_debug #(
        .NB(32),
        .DATA_BITS(8),
        .NUMBER_REGISTERS(NR)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_uart_rx_ready(rx_ready),
        .i_uart_rx_data(rx_data),
        .i_uart_tx_done(tx_done),
        .i_mips_pc(pc),
        .i_mips_register(reg_rd),
        .i_mips_alu_result(alu),
        .o_mips_register_number(reg_num),
        .o_uart_tx_data(tx_data),
        .o_uart_tx_ready(tx_ready),
        .o_step(step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: read data lags the address by one cycle.
    always @(posedge clk) reg_rd <= regs[reg_num];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next cycle with tx_ready high and return its byte.
    task automatic get_byte(output logic [7:0] b);
        int n;
        for (n = 0; n < 20; n++) begin
            tick();
            if (step) step_seen = 1'b1;
            if (tx_ready) break;
        end
        check_val("tx_ready_rise", 32'(tx_ready), 32'd1);
        b = tx_data;
    endtask

    logic [7:0]  b;
    logic [31:0] word;

    initial begin
        checks    = 0;
        errors    = 0;
        step_seen = 1'b0;
        rst       = 1'b1;
        rx_ready  = 1'b0;
        rx_data   = 8'h00;
        tx_done   = 1'b0;
        pc        = 32'h0;
        alu       = 32'hdeadbeef;
        regs[0] = 32'h01234567;
        regs[1] = 32'h89abcdef;
        regs[2] = 32'hfedcba98;
        regs[3] = 32'h5a5aa5a5;
        regs[4] = 32'h00ff7f80;
        regs[5] = 32'h0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_val("rst_tx_data", 32'(tx_data), 32'h0);
        check_val("rst_tx_ready", 32'(tx_ready), 32'h0);
        check_val("rst_step", 32'(step), 32'h0);
        check_val("rst_reg_num", 32'(reg_num), 32'h0);

        // Non-step byte, first not valid, then valid: nothing happens
        rx_data = 8'h44;
        tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("ignore_step", 32'(step), 32'h0);
            check_val("ignore_tx_ready", 32'(tx_ready), 32'h0);
            tick();
        end

        // Step command; PC held through the latch edge, then cleared
        pc       = 32'h1ba5e93f;
        rx_data  = 8'h73;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check_val("step_pulse", 32'(step), 32'h1);
        check_val("step_tx_data", 32'(tx_data), 32'h0);
        check_val("step_tx_ready", 32'(tx_ready), 32'h0);
        tick();
        check_val("step_falls", 32'(step), 32'h0);
        tick();
        pc = 32'h0;
        tick();
        check_val("pc_b0_ready", 32'(tx_ready), 32'h1);
        check_val("pc_b0_data", 32'(tx_data), 32'h1b);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("pc_b0_hold", 32'(tx_ready), 32'h1);
            check_val("pc_b0_hold_data", 32'(tx_data), 32'h1b);
        end

        // Done stuck high from here on
        tx_done = 1'b1;
        tick();
        check_val("ready_falls", 32'(tx_ready), 32'h0);
        get_byte(b);
        check_val("pc_b1", 32'(b), 32'ha5);
        get_byte(b);
        check_val("pc_b2", 32'(b), 32'he9);
        get_byte(b);
        check_val("pc_b3", 32'(b), 32'h3f);
        check_val("reg_num_before_r0", 32'(reg_num), 32'h0);
        tick();
        check_val("gap_after_pc", 32'(tx_ready), 32'h0);

        // Register groups
        for (int k = 0; k < NR; k++) begin
            word = 32'h0;
            for (int j = 0; j < 4; j++) begin
                get_byte(b);
                word = {word[23:0], b};
            end
            check_val($sformatf("reg%0d", k), word, regs[k]);
            check_val($sformatf("reg_num_after_r%0d", k), 32'(reg_num), 32'(k + 1));
            if (k == NR - 1) alu = 32'hc0ffee42;
        end

        // ALU word, changed just after the last register byte
        word = 32'h0;
        for (int j = 0; j < 4; j++) begin
            get_byte(b);
            word = {word[23:0], b};
        end
        check_val("alu_word", word, 32'hc0ffee42);
        check_val("no_step_in_frame", 32'(step_seen), 32'h0);

        // Back to IDLE with outputs cleared
        repeat (3) tick();
        check_val("idle_tx_data", 32'(tx_data), 32'h0);
        check_val("idle_tx_ready", 32'(tx_ready), 32'h0);
        check_val("idle_reg_num", 32'(reg_num), 32'h0);
        check_val("idle_step", 32'(step), 32'h0);

        // Mid-frame reset
        tx_done  = 1'b0;
        pc       = 32'h89abcdef;
        rx_data  = 8'h73;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check_val("step2_pulse", 32'(step), 32'h1);
        repeat (3) tick();
        check_val("f2_b0_ready", 32'(tx_ready), 32'h1);
        check_val("f2_b0_data", 32'(tx_data), 32'h89);
        rst = 1'b1;
        tick();
        check_val("mid_rst_tx_ready", 32'(tx_ready), 32'h0);
        check_val("mid_rst_tx_data", 32'(tx_data), 32'h0);
        check_val("mid_rst_step", 32'(step), 32'h0);
        check_val("mid_rst_reg_num", 32'(reg_num), 32'h0);
        rst     = 1'b0;
        tx_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("post_rst_quiet", 32'(tx_ready), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
